// File: rtl/mem_port_arbiter.sv
// Shares one single-ported memory between instruction fetch and load/store.
// One transaction in flight; data wins ties unless fetch has been starved.
module mem_port_arbiter #(
  parameter int ADDR_W       = 32,
  parameter int DATA_W       = 32,
  parameter int STARVE_LIMIT = 3
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                i_req,
  input  logic [ADDR_W-1:0]   i_addr,
  output logic [DATA_W-1:0]   i_rdata,
  output logic                i_ready,
  input  logic                d_req,
  input  logic                d_we,
  input  logic [ADDR_W-1:0]   d_addr,
  input  logic [DATA_W-1:0]   d_wdata,
  input  logic [DATA_W/8-1:0] d_wstrb,
  output logic [DATA_W-1:0]   d_rdata,
  output logic                d_ready,
  output logic                m_req,
  output logic                m_we,
  output logic [ADDR_W-1:0]   m_addr,
  output logic [DATA_W-1:0]   m_wdata,
  output logic [DATA_W/8-1:0] m_wstrb,
  input  logic                m_gnt,
  input  logic                m_rvalid,
  input  logic [DATA_W-1:0]   m_rdata,
  output logic                stall_if,
  output logic                stall_mem,
  output logic                protocol_err
);
  localparam int STRB_W = DATA_W / 8;
  localparam logic [3:0] LIMIT = 4'(STARVE_LIMIT);

  typedef enum logic [1:0] {IDLE, ISSUE, WAIT, RESP} state_t;

  state_t              state_q, state_d;
  logic                owner_q, owner_d;  // 1: data side owns the transaction
  logic [3:0]          starve_q, starve_d;
  logic                m_req_q, m_req_d;
  logic                m_we_q, m_we_d;
  logic [ADDR_W-1:0]   m_addr_q, m_addr_d;
  logic [DATA_W-1:0]   m_wdata_q, m_wdata_d;
  logic [STRB_W-1:0]   m_wstrb_q, m_wstrb_d;
  logic [DATA_W-1:0]   i_rdata_q, i_rdata_d;
  logic [DATA_W-1:0]   d_rdata_q, d_rdata_d;
  logic                i_ready_q, i_ready_d;
  logic                d_ready_q, d_ready_d;
  logic                perr_q, perr_d;
  logic                fetch_wins;
  logic                resp_done;

  always_comb begin
    state_d    = state_q;
    owner_d    = owner_q;
    starve_d   = starve_q;
    m_req_d    = m_req_q;
    m_we_d     = m_we_q;
    m_addr_d   = m_addr_q;
    m_wdata_d  = m_wdata_q;
    m_wstrb_d  = m_wstrb_q;
    i_rdata_d  = i_rdata_q;
    d_rdata_d  = d_rdata_q;
    i_ready_d  = 1'b0;
    d_ready_d  = 1'b0;
    perr_d     = perr_q;
    fetch_wins = 1'b0;
    resp_done  = 1'b0;
    case (state_q)
      IDLE: begin
        perr_d = perr_q | m_rvalid;
        if (i_req || d_req) begin
          fetch_wins = i_req && (!d_req || starve_q == LIMIT);
          owner_d    = !fetch_wins;
          m_req_d    = 1'b1;
          state_d    = ISSUE;
          if (fetch_wins) begin
            m_addr_d  = i_addr;
            m_we_d    = 1'b0;
            m_wdata_d = '0;
            m_wstrb_d = '0;
            starve_d  = '0;
          end else begin
            m_addr_d  = d_addr;
            m_we_d    = d_we;
            m_wdata_d = d_wdata;
            m_wstrb_d = d_wstrb;
            // Only data grants that bypass a waiting fetch count as starvation.
            starve_d  = !i_req ? 4'd0 : (starve_q == LIMIT) ? LIMIT : starve_q + 4'd1;
          end
        end
      end
      ISSUE: begin
        if (m_gnt) begin
          m_req_d = 1'b0;
          if (m_rvalid) resp_done = 1'b1;
          else          state_d   = WAIT;
        end
      end
      WAIT: begin
        if (m_rvalid) resp_done = 1'b1;
      end
      RESP: begin
        perr_d  = perr_q | m_rvalid;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
    if (resp_done) begin
      state_d = RESP;
      if (owner_q) begin
        d_ready_d = 1'b1;
        if (!m_we_q) d_rdata_d = m_rdata;
      end else begin
        i_ready_d = 1'b1;
        i_rdata_d = m_rdata;
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q   <= IDLE;
      owner_q   <= 1'b0;
      starve_q  <= '0;
      m_req_q   <= 1'b0;
      m_we_q    <= 1'b0;
      m_addr_q  <= '0;
      m_wdata_q <= '0;
      m_wstrb_q <= '0;
      i_rdata_q <= '0;
      d_rdata_q <= '0;
      i_ready_q <= 1'b0;
      d_ready_q <= 1'b0;
      perr_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      owner_q   <= owner_d;
      starve_q  <= starve_d;
      m_req_q   <= m_req_d;
      m_we_q    <= m_we_d;
      m_addr_q  <= m_addr_d;
      m_wdata_q <= m_wdata_d;
      m_wstrb_q <= m_wstrb_d;
      i_rdata_q <= i_rdata_d;
      d_rdata_q <= d_rdata_d;
      i_ready_q <= i_ready_d;
      d_ready_q <= d_ready_d;
      perr_q    <= perr_d;
    end
  end

  assign m_req        = m_req_q;
  assign m_we         = m_we_q;
  assign m_addr       = m_addr_q;
  assign m_wdata      = m_wdata_q;
  assign m_wstrb      = m_wstrb_q;
  assign i_rdata      = i_rdata_q;
  assign d_rdata      = d_rdata_q;
  assign i_ready      = i_ready_q;
  assign d_ready      = d_ready_q;
  assign protocol_err = perr_q;
  assign stall_if     = i_req & ~i_ready_q;
  assign stall_mem    = d_req & ~d_ready_q;
endmodule

// File: tb/tb_mem_port_arbiter.sv
// Bench for mem_port_arbiter: directed vector table, reset/starvation/spurious
// sequences, and a randomized run against a requester-side reference model.
module tb_mem_port_arbiter;
  localparam int LIMIT = 3;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        i_req = 1'b0, d_req = 1'b0, d_we = 1'b0;
  logic [31:0] i_addr = '0, d_addr = '0, d_wdata = '0;
  logic [3:0]  d_wstrb = '0;
  logic        tb_gnt = 1'b0, tb_rvalid = 1'b0;
  logic [31:0] tb_rdata = '0;
  logic        m_gnt, m_rvalid;
  logic [31:0] m_rdata;
  logic [31:0] i_rdata, d_rdata, m_addr, m_wdata;
  logic        i_ready, d_ready, m_req, m_we, stall_if, stall_mem, protocol_err;
  logic [3:0]  m_wstrb;

  logic        auto_mem = 1'b0, mem_fast = 1'b0, mem_busy = 1'b0;
  logic        mem_gnt = 1'b0, mem_rvalid = 1'b0;
  logic [31:0] mem_rdata = '0, mem_resp = '0;
  int          mem_dly = 0;
  logic [31:0] mem_arr [logic [31:0]];
  logic [31:0] ref_mem [logic [31:0]];

  int n_chk = 0, n_fail = 0;

  assign m_gnt    = auto_mem ? mem_gnt    : tb_gnt;
  assign m_rvalid = auto_mem ? mem_rvalid : tb_rvalid;
  assign m_rdata  = auto_mem ? mem_rdata  : tb_rdata;

  mem_port_arbiter #(.ADDR_W(32), .DATA_W(32), .STARVE_LIMIT(LIMIT)) dut (
    .clk(clk), .reset(reset),
    .i_req(i_req), .i_addr(i_addr), .i_rdata(i_rdata), .i_ready(i_ready),
    .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata), .d_wstrb(d_wstrb),
    .d_rdata(d_rdata), .d_ready(d_ready),
    .m_req(m_req), .m_we(m_we), .m_addr(m_addr), .m_wdata(m_wdata), .m_wstrb(m_wstrb),
    .m_gnt(m_gnt), .m_rvalid(m_rvalid), .m_rdata(m_rdata),
    .stall_if(stall_if), .stall_mem(stall_mem), .protocol_err(protocol_err)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] init_val(input logic [31:0] a);
    return (a * 32'h9E3779B1) ^ 32'h5A5A0F0F;
  endfunction

  function automatic logic [31:0] merge(input logic [31:0] old, input logic [31:0] wd,
                                       input logic [3:0] st);
    logic [31:0] r;
    r = old;
    for (int b = 0; b < 4; b++) if (st[b]) r[8*b +: 8] = wd[8*b +: 8];
    return r;
  endfunction

  function automatic logic [31:0] ref_rd(input logic [31:0] a);
    return ref_mem.exists(a) ? ref_mem[a] : init_val(a);
  endfunction

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, "_m_req"}, m_req, 0);
    chk({tag, "_m_we"}, m_we, 0);
    chk({tag, "_m_addr"}, m_addr, 0);
    chk({tag, "_m_wdata"}, m_wdata, 0);
    chk({tag, "_m_wstrb"}, m_wstrb, 0);
    chk({tag, "_i_ready"}, i_ready, 0);
    chk({tag, "_d_ready"}, d_ready, 0);
    chk({tag, "_i_rdata"}, i_rdata, 0);
    chk({tag, "_d_rdata"}, d_rdata, 0);
    chk({tag, "_stalls"}, {stall_if, stall_mem}, 0);
    chk({tag, "_perr"}, protocol_err, 0);
  endtask

  // Memory: random grant delay and response latency; stores update mem_arr.
  always @(posedge clk) begin
    #1;
    mem_gnt = 1'b0;
    mem_rvalid = 1'b0;
    if (!auto_mem) mem_busy = 1'b0;
    else if (mem_busy) begin
      if (mem_dly == 0) begin
        mem_rvalid = 1'b1;
        mem_rdata = mem_resp;
        mem_busy = 1'b0;
      end else mem_dly--;
    end else if (m_req && (mem_fast || $urandom_range(0, 2) != 0)) begin
      mem_gnt = 1'b1;
      if (m_we) begin
        mem_arr[m_addr] = merge(mem_arr.exists(m_addr) ? mem_arr[m_addr] : init_val(m_addr),
                                m_wdata, m_wstrb);
        mem_resp = $urandom;
      end else mem_resp = mem_arr.exists(m_addr) ? mem_arr[m_addr] : init_val(m_addr);
      mem_dly = mem_fast ? 1 : int'($urandom_range(0, 2));
      if (mem_dly == 0) begin
        mem_rvalid = 1'b1;
        mem_rdata = mem_resp;
      end else begin
        mem_busy = 1'b1;
        mem_dly--;
      end
    end
  end

  typedef struct {
    logic ireq; logic [31:0] iaddr;
    logic dreq; logic dwe; logic [31:0] daddr; logic [31:0] dwdata; logic [3:0] dwstrb;
    logic gnt; logic rvalid; logic [31:0] rdata;
    logic e_mreq; logic [31:0] e_maddr; logic e_mwe; logic [3:0] e_mwstrb; logic [31:0] e_mwdata;
    logic e_irdy; logic e_drdy; logic e_sif; logic e_smem;
    logic [31:0] e_irdata; logic [31:0] e_drdata;
  } vec_t;

  vec_t tv[$];

  initial begin
    logic        p_ireq, p_dreq, prev_mreq, in_flight, fl_data, exp_data;
    logic        i_done, d_done, di, dd;
    logic [5:0]  order;
    int          streak, ng, ni, nd;

    // single fetch
    tv.push_back('{1,'h100, 0,0,0,0,0, 0,0,0,          0,0,0,0,0,              0,0,1,0, 0,0});
    tv.push_back('{1,'h100, 0,0,0,0,0, 1,0,0,          1,'h100,0,0,0,          0,0,1,0, 0,0});
    tv.push_back('{1,'h100, 0,0,0,0,0, 0,1,'h00500093, 0,0,0,0,0,              0,0,1,0, 0,0});
    tv.push_back('{1,'h100, 0,0,0,0,0, 0,0,0,          0,0,0,0,0,              1,0,0,0, 'h00500093,0});
    tv.push_back('{0,'h100, 0,0,0,0,0, 0,0,0,          0,0,0,0,0,              0,0,0,0, 'h00500093,0});
    // simultaneous store + fetch: store first, then fetch
    tv.push_back('{1,'h104, 1,1,'h2000,'hDEADBEEF,'hF, 0,0,0, 0,0,0,0,0,       0,0,1,1, 'h00500093,0});
    tv.push_back('{1,'h104, 1,1,'h2000,'hDEADBEEF,'hF, 1,0,0, 1,'h2000,1,'hF,'hDEADBEEF, 0,0,1,1, 'h00500093,0});
    tv.push_back('{1,'h104, 1,1,'h2000,'hDEADBEEF,'hF, 0,1,'h11111111, 0,0,0,0,0, 0,0,1,1, 'h00500093,0});
    tv.push_back('{1,'h104, 1,1,'h2000,'hDEADBEEF,'hF, 0,0,0, 0,0,0,0,0,       0,1,1,0, 'h00500093,0});
    tv.push_back('{1,'h104, 0,0,0,0,0, 0,0,0,          0,0,0,0,0,              0,0,1,0, 'h00500093,0});
    tv.push_back('{1,'h104, 0,0,0,0,0, 1,0,0,          1,'h104,0,0,0,          0,0,1,0, 'h00500093,0});
    tv.push_back('{1,'h104, 0,0,0,0,0, 0,1,'h00A00113, 0,0,0,0,0,              0,0,1,0, 'h00500093,0});
    tv.push_back('{1,'h104, 0,0,0,0,0, 0,0,0,          0,0,0,0,0,              1,0,0,0, 'h00A00113,0});
    tv.push_back('{0,'h104, 0,0,0,0,0, 0,0,0,          0,0,0,0,0,              0,0,0,0, 'h00A00113,0});
    // delayed grant with same-cycle response; request inputs change after latch
    tv.push_back('{0,0, 1,0,'h3000,0,0, 0,0,0,         0,0,0,0,0,              0,0,0,1, 'h00A00113,0});
    tv.push_back('{0,0, 1,0,'h3000,0,0, 0,0,0,         1,'h3000,0,0,0,         0,0,0,1, 'h00A00113,0});
    tv.push_back('{0,0, 1,0,'h3000,0,0, 0,0,0,         1,'h3000,0,0,0,         0,0,0,1, 'h00A00113,0});
    tv.push_back('{0,0, 1,0,'h3FFC,0,0, 0,0,0,         1,'h3000,0,0,0,         0,0,0,1, 'h00A00113,0});
    tv.push_back('{0,0, 1,1,'h3FFC,0,0, 0,0,0,         1,'h3000,0,0,0,         0,0,0,1, 'h00A00113,0});
    tv.push_back('{0,0, 1,1,'h3FFC,0,0, 0,0,0,         1,'h3000,0,0,0,         0,0,0,1, 'h00A00113,0});
    tv.push_back('{0,0, 1,1,'h3FFC,0,0, 1,1,'hCAFEF00D, 1,'h3000,0,0,0,        0,0,0,1, 'h00A00113,0});
    tv.push_back('{0,0, 1,1,'h3FFC,0,0, 0,0,0,         0,0,0,0,0,              0,1,0,0, 'h00A00113,'hCAFEF00D});
    tv.push_back('{0,0, 0,0,0,0,0, 0,0,0,              0,0,0,0,0,              0,0,0,0, 'h00A00113,'hCAFEF00D});

    repeat (3) @(posedge clk);
    #1;
    chk_all_zero("reset");
    reset = 1'b0;

    foreach (tv[k]) begin
      i_req = tv[k].ireq;   i_addr = tv[k].iaddr;
      d_req = tv[k].dreq;   d_we = tv[k].dwe;   d_addr = tv[k].daddr;
      d_wdata = tv[k].dwdata; d_wstrb = tv[k].dwstrb;
      tb_gnt = tv[k].gnt;   tb_rvalid = tv[k].rvalid; tb_rdata = tv[k].rdata;
      #1;
      chk($sformatf("v%0d_m_req", k), m_req, tv[k].e_mreq);
      if (tv[k].e_mreq) begin
        chk($sformatf("v%0d_m_addr", k), m_addr, tv[k].e_maddr);
        chk($sformatf("v%0d_m_we", k), m_we, tv[k].e_mwe);
        chk($sformatf("v%0d_m_wstrb", k), m_wstrb, tv[k].e_mwstrb);
        if (tv[k].e_mwe) chk($sformatf("v%0d_m_wdata", k), m_wdata, tv[k].e_mwdata);
      end
      chk($sformatf("v%0d_ready", k), {i_ready, d_ready}, {tv[k].e_irdy, tv[k].e_drdy});
      chk($sformatf("v%0d_stall", k), {stall_if, stall_mem}, {tv[k].e_sif, tv[k].e_smem});
      chk($sformatf("v%0d_i_rdata", k), i_rdata, tv[k].e_irdata);
      chk($sformatf("v%0d_d_rdata", k), d_rdata, tv[k].e_drdata);
      chk($sformatf("v%0d_perr", k), protocol_err, 0);
      tick();
    end

    // reset while a load sits in WAIT
    d_req = 1; d_we = 0; d_addr = 32'h40; tick();
    tb_gnt = 1; tick();
    tb_gnt = 0;
    reset = 1; d_req = 0;
    #1;
    chk_all_zero("rst_wait");
    repeat (2) begin tick(); chk("rst_hold_d_ready", d_ready, 0); end
    reset = 0;
    repeat (3) begin tick(); chk("post_rst_idle", {d_ready, m_req}, 0); end
    i_req = 1; i_addr = 0; tick();
    chk("post_rst_fetch_req", {m_req, m_addr}, {1'b1, 32'h0});
    tb_gnt = 1; tick();
    tb_gnt = 0; tb_rvalid = 1; tb_rdata = 32'h00000013; tick();
    tb_rvalid = 0;
    #1;
    chk("post_rst_fetch_done", {i_ready, d_ready, i_rdata}, {2'b10, 32'h13});
    i_req = 0; tick();
    chk("post_rst_ready_pulse", i_ready, 0);

    // randomized traffic against the requester-side model
    reset = 1; tick(); tick(); reset = 0;
    auto_mem = 1; mem_fast = 0;
    p_ireq = 0; p_dreq = 0; prev_mreq = 0; in_flight = 0; fl_data = 0;
    i_done = 0; d_done = 0; streak = 0;
    for (int cyc = 0; cyc < 3000; cyc++) begin
      if (i_done) begin i_req = 0; i_done = 0; end
      if (d_done) begin d_req = 0; d_done = 0; end
      if (cyc < 2800) begin
        if (!i_req && $urandom_range(0, 2) == 0) begin
          i_req = 1; i_addr = 32'($urandom_range(0, 15)) << 2;
        end
        if (!d_req && $urandom_range(0, 2) == 0) begin
          d_req = 1; d_we = 1'($urandom_range(0, 1));
          d_addr = 32'($urandom_range(0, 15)) << 2;
          d_wdata = $urandom; d_wstrb = 4'($urandom_range(0, 15));
        end
      end
      #1;
      chk("rnd_stall_if", stall_if, i_req && !i_ready);
      chk("rnd_stall_mem", stall_mem, d_req && !d_ready);
      if (m_req && !prev_mreq) begin
        exp_data = p_dreq && !(p_ireq && streak == LIMIT);
        chk("rnd_grant", {m_we, m_addr}, exp_data ? {d_we, d_addr} : {1'b0, i_addr});
        if (exp_data) streak = p_ireq ? ((streak < LIMIT) ? streak + 1 : streak) : 0;
        else streak = 0;
        in_flight = 1; fl_data = exp_data;
      end
      prev_mreq = m_req;
      if (i_ready) begin
        chk("rnd_i_owner", in_flight && !fl_data, 1);
        chk("rnd_i_rdata", i_rdata, ref_rd(i_addr));
        in_flight = 0; i_done = 1;
      end
      if (d_ready) begin
        chk("rnd_d_owner", in_flight && fl_data, 1);
        if (d_we) ref_mem[d_addr] = merge(ref_rd(d_addr), d_wdata, d_wstrb);
        else chk("rnd_d_rdata", d_rdata, ref_rd(d_addr));
        in_flight = 0; d_done = 1;
      end
      p_ireq = i_req; p_dreq = d_req;
      tick();
    end
    chk("rnd_drained", {i_req, d_req, in_flight}, 0);
    chk("rnd_no_perr", protocol_err, 0);

    // starvation: fetch held while five loads stream back to back
    auto_mem = 0;
    reset = 1; tick(); tick(); reset = 0;
    auto_mem = 1; mem_fast = 1;
    i_req = 1; i_addr = 32'h200; d_req = 1; d_we = 0; d_addr = 32'h300;
    nd = 5; ng = 0; ni = 0; order = '0; prev_mreq = 0;
    for (int c = 0; c < 100 && (nd > 0 || i_req); c++) begin
      #1;
      if (m_req && !prev_mreq) begin
        order = {order[4:0], m_addr == 32'h200};
        ng++;
      end
      prev_mreq = m_req;
      if (i_ready) ni++;
      di = i_ready; dd = d_ready;
      tick();
      if (di) i_req = 0;
      if (dd) begin nd--; d_req = (nd > 0); d_addr = d_addr + 4; end
    end
    chk("starve_grants", ng, 6);
    chk("starve_order", order, 6'b000100);
    chk("starve_i_ready_cnt", ni, 1);
    chk("starve_i_rdata", i_rdata, init_val(32'h200));
    chk("starve_d_rdata", d_rdata, init_val(32'h310));

    // spurious response in IDLE
    auto_mem = 0;
    tb_rvalid = 1; tb_rdata = 32'h12345678;
    #1;
    chk("spur_no_ready_now", {i_ready, d_ready}, 0);
    tick();
    tb_rvalid = 0;
    #1;
    chk("spur_perr", protocol_err, 1);
    chk("spur_no_ready", {i_ready, d_ready}, 0);
    chk("spur_i_rdata", i_rdata, init_val(32'h200));
    chk("spur_d_rdata", d_rdata, init_val(32'h310));
    repeat (3) tick();
    chk("spur_perr_sticky", protocol_err, 1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
